spi_slave_sync: RTL and testbench

SPI slave clocked entirely by the system clock i_clk, for blocks that must exchange bytes with an external spi_master without running logic on the SPI clock. It oversamples SCLK, slave select and MOSI through synchronizers, detects edges, and supports all four SPI modes with 8-bit frames, MSB first. The local side has a one-entry TX holding buffer with a valid/ready handshake and a single-cycle RX valid pulse.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 45 ++++
 rtl/spi_slave_sync.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared constants for the system-clocked SPI slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int CPOL_BIT   = 1;
    localparam int CPHA_BIT   = 0;
    localparam int FRAME_BITS = 8;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module   : spi_sync_edge
// Brief    : N-stage synchronizer with registered rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/spi_slave_sync.sv
// ============================================================================
// Module   : spi_slave_sync
// Brief    : SPI slave (modes 0-3, 8-bit MSB first) run on the system clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [FRAME_BITS-1:0] DEFAULT_TX  = 8'hFF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [1:0]            i_mode,
    input  logic                  i_sclk,
    input  logic                  i_slave_select,
    input  logic                  i_MOSI,
    output logic                  o_MISO,
    output logic                  o_miso_oe,
    input  logic [FRAME_BITS-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_busy,
    output logic                  o_underrun
);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_sel_q, w_sel_rise, w_sel_fall;
    logic w_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_sclk),
        .o_q     (w_sclk_q),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sel_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_slave_select),
        .o_q     (w_sel_q),
        .o_rise  (w_sel_rise),
        .o_fall  (w_sel_fall)
    );

    // Only SCLK edges matter; its level is intentionally left unused.
    assign w_unused = w_sclk_q;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi;

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [1:0]             r_mode;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_tx_full;
    logic [FRAME_BITS-1:0]  r_tx_buf;
    logic [FRAME_BITS-2:0]  r_tx_sr;
    logic                   r_miso;
    logic [FRAME_BITS-2:0]  r_rx_sr;
    logic [FRAME_BITS-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic                   r_underrun;

    logic                   w_active;
    logic                   w_lead, w_trail;
    logic                   w_sample, w_shift;
    logic                   w_tx_write;
    logic [FRAME_BITS-1:0]  w_load_byte;
    logic                   w_first_bit;
    logic                   w_last_bit;

    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_active    = (r_state == ST_ACTIVE);
    assign w_lead      = r_mode[CPOL_BIT] ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = r_mode[CPOL_BIT] ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = w_active & ~w_sel_fall & (r_mode[CPHA_BIT] ? w_trail : w_lead);
    assign w_shift     = w_active & ~w_sel_fall & (r_mode[CPHA_BIT] ? w_lead : w_trail);
    assign w_tx_write  = i_tx_valid & ~r_tx_full;
    assign w_load_byte = r_tx_full ? r_tx_buf : DEFAULT_TX;
    assign w_first_bit = (r_bit_cnt == '0);
    assign w_last_bit  = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_sel_rise) w_state_next = ST_ACTIVE;
            ST_ACTIVE: if (w_sel_fall) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mosi_sync <= '0;
            r_mode      <= 2'b00;
            r_bit_cnt   <= '0;
            r_tx_full   <= 1'b0;
            r_tx_buf    <= '0;
            r_tx_sr     <= '0;
            r_miso      <= 1'b0;
            r_rx_sr     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_MOSI};
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;

            if (w_tx_write) begin
                r_tx_full <= 1'b1;
                r_tx_buf  <= i_tx_data;
            end

            if (!w_active) begin
                if (w_sel_rise) begin
                    r_mode    <= i_mode;
                    r_bit_cnt <= '0;
                    // CPHA=0 needs the MSB on the wire before the first edge.
                    if (!i_mode[CPHA_BIT]) begin
                        r_miso  <= w_load_byte[FRAME_BITS-1];
                        r_tx_sr <= w_load_byte[FRAME_BITS-2:0];
                    end
                end
            end else if (w_sel_fall) begin
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
            end else if (w_sample) begin
                r_rx_sr   <= {r_rx_sr[FRAME_BITS-3:0], w_mosi};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                if (w_first_bit) begin
                    if (r_tx_full) begin
                        r_tx_full <= 1'b0;
                    end else begin
                        r_underrun <= 1'b1;
                    end
                end
                if (w_last_bit) begin
                    r_rx_data  <= {r_rx_sr, w_mosi};
                    r_rx_valid <= 1'b1;
                    r_bit_cnt  <= '0;
                end
            end else if (w_shift) begin
                if (w_first_bit) begin
                    r_miso  <= w_load_byte[FRAME_BITS-1];
                    r_tx_sr <= w_load_byte[FRAME_BITS-2:0];
                end else begin
                    r_miso  <= r_tx_sr[FRAME_BITS-2];
                    r_tx_sr <= {r_tx_sr[FRAME_BITS-3:0], 1'b0};
                end
            end
        end
    end

    assign o_MISO     = r_miso & w_active;
    assign o_miso_oe  = w_active;
    assign o_tx_ready = ~r_tx_full;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_busy     = w_sel_q;
    assign o_underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
// ============================================================================
// Module   : tb_spi_slave_sync
// Brief    : Directed self-checking bench for spi_slave_sync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_sync;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       sclk = 1'b0;
    logic       ss = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    int         rx_cnt = 0;
    int         ur_cnt = 0;
    int         bad_edge = 0;
    logic [7:0] rx_last = 8'h00;
    logic [7:0] rx_prev = 8'h00;
    logic       mon_en = 1'b0;
    logic       prev_oe = 1'b0;
    logic       prev_miso = 1'b0;

    always #5 clk = ~clk;

    spi_slave_sync #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_mode         (mode),
        .i_sclk         (sclk),
        .i_slave_select (ss),
        .i_MOSI         (mosi),
        .o_MISO         (miso),
        .o_miso_oe      (miso_oe),
        .i_tx_data      (tx_data),
        .i_tx_valid     (tx_valid),
        .o_tx_ready     (tx_ready),
        .o_rx_data      (rx_data),
        .o_rx_valid     (rx_valid),
        .o_busy         (busy),
        .o_underrun     (underrun)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_prev = rx_last;
            rx_last = rx_data;
        end
        if (underrun) ur_cnt++;
        if (mon_en && prev_oe && miso_oe && (miso !== prev_miso) && sclk) bad_edge++;
        prev_oe   = miso_oe;
        prev_miso = miso;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int k = 0;
        while (!tx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) check("tx_write_ready_timeout", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic spi_select(input logic [1:0] m);
        mode = m;
        sclk = m[1];
        mosi = 1'b0;
        cycles(2 * HALF);
        ss = 1'b1;
        cycles(HALF);
    endtask

    task automatic spi_deselect();
        ss = 1'b0;
        cycles(2 * HALF);
    endtask

    task automatic spi_frame(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!mode[0]) begin
                mosi = tx[7-i];
                cycles(HALF);
                rx[7-i] = miso;
                sclk = ~sclk;
                cycles(HALF);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = tx[7-i];
                cycles(HALF);
                rx[7-i] = miso;
                sclk = ~sclk;
                cycles(HALF);
            end
        end
        cycles(HALF);
    endtask

    initial begin
        logic [7:0] mrx;
        logic [7:0] mrx2;
        int         rx0;
        int         ur0;

        // Reset state
        #23;
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cycles(4);

        // Mode 0: CD out, AB in
        rx0 = rx_cnt; ur0 = ur_cnt;
        tx_write(8'hCD);
        check("m0_ready_after_write", {31'd0, tx_ready}, 32'd0);
        spi_select(2'b00);
        check("m0_busy", {31'd0, busy}, 32'd1);
        check("m0_oe", {31'd0, miso_oe}, 32'd1);
        spi_frame(8'hAB, 8, mrx);
        check("m0_master_rx", {24'd0, mrx}, 32'hCD);
        check("m0_rx_data", {24'd0, rx_data}, 32'hAB);
        check("m0_rx_pulses", rx_cnt - rx0, 32'd1);
        check("m0_underrun", ur_cnt - ur0, 32'd0);
        check("m0_tx_ready", {31'd0, tx_ready}, 32'd1);
        spi_deselect();
        check("m0_busy_low", {31'd0, busy}, 32'd0);
        check("m0_oe_low", {31'd0, miso_oe}, 32'd0);

        // Mode 3: same bytes, MISO moves only after falling SCLK
        rx0 = rx_cnt; ur0 = ur_cnt; bad_edge = 0;
        tx_write(8'hCD);
        mon_en = 1'b1;
        spi_select(2'b11);
        spi_frame(8'hAB, 8, mrx);
        mon_en = 1'b0;
        check("m3_master_rx", {24'd0, mrx}, 32'hCD);
        check("m3_rx_data", {24'd0, rx_data}, 32'hAB);
        check("m3_rx_pulses", rx_cnt - rx0, 32'd1);
        check("m3_miso_on_rise", bad_edge, 32'd0);
        check("m3_underrun", ur_cnt - ur0, 32'd0);
        spi_deselect();

        // Mode 1: two back-to-back frames in one select
        rx0 = rx_cnt; ur0 = ur_cnt;
        tx_write(8'h56);
        spi_select(2'b01);
        fork
            spi_frame(8'h12, 8, mrx);
            tx_write(8'h78);
        join
        spi_frame(8'h34, 8, mrx2);
        check("m1_master_rx0", {24'd0, mrx}, 32'h56);
        check("m1_master_rx1", {24'd0, mrx2}, 32'h78);
        check("m1_rx_first", {24'd0, rx_prev}, 32'h12);
        check("m1_rx_second", {24'd0, rx_last}, 32'h34);
        check("m1_rx_pulses", rx_cnt - rx0, 32'd2);
        check("m1_underrun", ur_cnt - ur0, 32'd0);
        spi_deselect();

        // Mode 0 with empty TX buffer
        rx0 = rx_cnt; ur0 = ur_cnt;
        spi_select(2'b00);
        spi_frame(8'h0F, 8, mrx);
        check("ur_master_rx", {24'd0, mrx}, 32'hFF);
        check("ur_pulses", ur_cnt - ur0, 32'd1);
        check("ur_rx_data", {24'd0, rx_data}, 32'h0F);
        spi_deselect();

        // Mode 2: abort after 4 bits, then a full frame
        rx0 = rx_cnt; ur0 = ur_cnt;
        spi_select(2'b10);
        spi_frame(8'hF0, 4, mrx);
        spi_deselect();
        check("m2_abort_no_rx", rx_cnt - rx0, 32'd0);
        check("m2_abort_busy", {31'd0, busy}, 32'd0);
        check("m2_abort_rx_hold", {24'd0, rx_data}, 32'h0F);
        check("m2_abort_underrun", ur_cnt - ur0, 32'd1);
        tx_write(8'h96);
        spi_select(2'b10);
        spi_frame(8'h3C, 8, mrx);
        spi_deselect();
        check("m2_master_rx", {24'd0, mrx}, 32'h96);
        check("m2_rx_data", {24'd0, rx_data}, 32'h3C);
        check("m2_rx_pulses", rx_cnt - rx0, 32'd1);

        // Deselect before any edge keeps the buffer
        tx_write(8'h5A);
        spi_select(2'b10);
        spi_deselect();
        check("keep_tx_ready", {31'd0, tx_ready}, 32'd0);
        spi_select(2'b00);
        spi_frame(8'hC3, 8, mrx);
        spi_deselect();
        check("keep_master_rx", {24'd0, mrx}, 32'h5A);
        check("keep_rx_data", {24'd0, rx_data}, 32'hC3);

        // Reset mid-frame
        rx0 = rx_cnt;
        tx_write(8'h11);
        spi_select(2'b00);
        spi_frame(8'h81, 4, mrx);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_miso", {31'd0, miso}, 32'd0);
        check("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mid_rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        ss = 1'b0;
        sclk = 1'b0;
        cycles(4);
        reset = 1'b0;
        cycles(2 * HALF);
        check("mid_rst_no_rx", rx_cnt - rx0, 32'd0);
        tx_write(8'h3E);
        spi_select(2'b00);
        spi_frame(8'hA5, 8, mrx);
        spi_deselect();
        check("post_rst_master_rx", {24'd0, mrx}, 32'h3E);
        check("post_rst_rx_data", {24'd0, rx_data}, 32'hA5);
        check("post_rst_rx_pulses", rx_cnt - rx0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
